iir_accum_ctrl: RTL and testbench

Sequencer that time-shares one combinational 16-bit sign-magnitude `adder` to sum a fixed number of product terms per IIR output sample, e.g. b0·x[n], b1·x[n-1], b2·x[n-2], a1·y[n-1] and a2·y[n-2] for a biquad. It sits between the coefficient multipliers and the output/feedback register. It accepts one term per cycle over a valid/ready handshake, drives the external adder, and presents the finished sum with a sticky overflow flag on a second valid/ready handshake.

---
 rtl/iir_accum_if.sv | 43 ++++
 rtl/iir_accum_ctrl.sv | 131 +++++++++++++
 tb/tb_iir_accum_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iir_accum_if.sv
// -----------------------------------------------------------------------------
// iir_accum_if
// Bundles the term handshake, the external adder hookup and the sum handshake
// of iir_accum_ctrl.
//
//   term_valid / term_ready / term_data : incoming product terms
//   add_a / add_b / add_result          : shared combinational adder
//   sum_valid / sum_ready / sum_data    : finished sample
//   sum_ovf                             : sticky magnitude overflow of sample
//   term_count                          : terms accepted in current sample
//
// Modports:
//   slave  - the accumulator controller
//   master - the surrounding datapath (multipliers, adder, output register)
// -----------------------------------------------------------------------------
interface iir_accum_if #(
   parameter int WIDTH = 16,
   parameter int TERMS = 5
);
   localparam int CNT_W = $clog2(TERMS + 1);

   logic             term_valid;
   logic             term_ready;
   logic [WIDTH-1:0] term_data;
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] add_result;
   logic             sum_valid;
   logic             sum_ready;
   logic [WIDTH-1:0] sum_data;
   logic             sum_ovf;
   logic [CNT_W-1:0] term_count;

   modport slave (
      input  term_valid, term_data, add_result, sum_ready,
      output term_ready, add_a, add_b, sum_valid, sum_data, sum_ovf, term_count
   );

   modport master (
      output term_valid, term_data, add_result, sum_ready,
      input  term_ready, add_a, add_b, sum_valid, sum_data, sum_ovf, term_count
   );
endinterface

// File: rtl/iir_accum_ctrl.sv
// -----------------------------------------------------------------------------
// iir_accum_ctrl
// Time-shares one external combinational sign-magnitude adder to sum TERMS
// product terms per IIR output sample. One term is accepted per cycle; the
// finished sum is held with a sticky overflow flag until downstream takes it.
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low reset
//   i_clear  - synchronous abort of the current sample (wins over handshakes)
//   bus      - iir_accum_if.slave: term handshake, adder operands/result,
//              sum handshake, overflow flag and term counter
//
// Number format: bit WIDTH-1 is the sign, bits WIDTH-2:0 the magnitude.
// -----------------------------------------------------------------------------
module iir_accum_ctrl #(
   parameter int WIDTH = 16,
   parameter int TERMS = 5
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_clear,
   iir_accum_if.slave    bus
);
   localparam int               CNT_W    = $clog2(TERMS + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TERMS - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TERMS);

   typedef enum logic {
      ST_ACCEPT = 1'b0,
      ST_HOLD   = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_acc;
   logic [CNT_W-1:0] r_count;
   logic             r_ovf;

   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_acc_nxt;
   logic [CNT_W-1:0] w_count_nxt;
   logic             w_ovf_nxt;

   // Sign-magnitude negative zero is folded to plain zero on every acc write,
   // so the sum output never shows 1000...0.
   function automatic logic [WIDTH-1:0] fold_neg_zero(input logic [WIDTH-1:0] v);
      if (v == {1'b1, {(WIDTH-1){1'b0}}})
         return '0;
      else
         return v;
   endfunction

   // A same-sign addition whose magnitude came out smaller than the running
   // magnitude has wrapped past the representable range.
   function automatic logic mag_wrapped(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        input logic [WIDTH-1:0] r);
      return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-2:0] < a[WIDTH-2:0]);
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_ACCEPT;
         r_acc   <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_count <= w_count_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_count_nxt = r_count;
      w_ovf_nxt   = r_ovf;

      bus.term_ready = 1'b0;
      bus.sum_valid  = 1'b0;
      bus.add_a      = r_acc;
      bus.add_b      = bus.term_data;
      bus.sum_data   = r_acc;
      bus.sum_ovf    = r_ovf;
      bus.term_count = r_count;

      case (r_state)
         ST_ACCEPT: begin
            bus.term_ready = 1'b1;
            if (bus.term_valid) begin
               // First term of a sample loads directly; the adder output is
               // meaningless then because acc still holds the previous sum.
               if (r_count == '0) begin
                  w_acc_nxt = fold_neg_zero(bus.term_data);
                  w_ovf_nxt = 1'b0;
               end else begin
                  w_acc_nxt = fold_neg_zero(bus.add_result);
                  w_ovf_nxt = r_ovf | mag_wrapped(r_acc, bus.term_data, bus.add_result);
               end
               if (r_count == LAST_IDX) begin
                  w_state_nxt = ST_HOLD;
                  w_count_nxt = FULL_CNT;
               end else begin
                  w_count_nxt = r_count + 1'b1;
               end
            end
         end
         ST_HOLD: begin
            bus.sum_valid = 1'b1;
            if (bus.sum_ready) begin
               // acc/ovf stay visible until the next first term overwrites them.
               w_state_nxt = ST_ACCEPT;
               w_count_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = ST_ACCEPT;
         end
      endcase

      // Abort outranks any accept or sum handshake in the same cycle.
      if (i_clear) begin
         w_state_nxt = ST_ACCEPT;
         w_acc_nxt   = '0;
         w_count_nxt = '0;
         w_ovf_nxt   = 1'b0;
      end
   end
endmodule

// File: tb/tb_iir_accum_ctrl.sv
// -----------------------------------------------------------------------------
// tb_iir_accum_ctrl
// Directed bench for iir_accum_ctrl with TERMS=3 and a behavioural
// sign-magnitude adder closing the loop.
// -----------------------------------------------------------------------------
module tb_iir_accum_ctrl;
   localparam int WIDTH = 16;
   localparam int TERMS = 3;

   logic clk;
   logic rst_n;
   logic clear;
   int   n_vec;
   int   n_err;

   iir_accum_if #(.WIDTH(WIDTH), .TERMS(TERMS)) bus ();

   iir_accum_ctrl #(.WIDTH(WIDTH), .TERMS(TERMS)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_clear (clear),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural sign-magnitude adder; on equal magnitudes with opposite
   // signs it returns the sign of operand B, which can yield negative zero.
   logic [14:0] ma, mb, msum;
   logic        sa, sb;
   always_comb begin
      ma   = bus.add_a[14:0];
      mb   = bus.add_b[14:0];
      sa   = bus.add_a[15];
      sb   = bus.add_b[15];
      msum = ma + mb;
      if (sa == sb)
         bus.add_result = {sa, msum};
      else if (ma > mb)
         bus.add_result = {sa, ma - mb};
      else
         bus.add_result = {sb, mb - ma};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents three terms on consecutive cycles; returns #1 after the third
   // accepting edge with term_valid low.
   task automatic feed3(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
      bus.term_valid = 1'b1;
      bus.term_data  = d0;
      tick();
      bus.term_data  = d1;
      tick();
      bus.term_data  = d2;
      tick();
      bus.term_valid = 1'b0;
      bus.term_data  = 16'h0000;
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      clear          = 1'b0;
      bus.sum_ready  = 1'b0;
      bus.term_valid = 1'b1;
      bus.term_data  = 16'h1234;
      tick();
      tick();
      n_vec++;
      if (bus.term_ready !== 1'b1) begin n_err++; $display("FAIL reset_term_ready: got %b want 1", bus.term_ready); end
      n_vec++;
      if (bus.sum_valid !== 1'b0) begin n_err++; $display("FAIL reset_sum_valid: got %b want 0", bus.sum_valid); end
      n_vec++;
      if (bus.sum_data !== 16'h0000) begin n_err++; $display("FAIL reset_sum_data: got %h want 0000", bus.sum_data); end
      n_vec++;
      if (bus.sum_ovf !== 1'b0) begin n_err++; $display("FAIL reset_sum_ovf: got %b want 0", bus.sum_ovf); end
      n_vec++;
      if (bus.term_count !== 2'd0) begin n_err++; $display("FAIL reset_term_count: got %0d want 0", bus.term_count); end
      n_vec++;
      if (bus.add_a !== 16'h0000) begin n_err++; $display("FAIL reset_add_a: got %h want 0000", bus.add_a); end
      rst_n          = 1'b1;
      bus.term_valid = 1'b0;
      tick();
      n_vec++;
      if (bus.term_count !== 2'd0) begin n_err++; $display("FAIL post_reset_count: got %0d want 0", bus.term_count); end
   endtask

   task automatic test_back_to_back();
      bus.sum_ready  = 1'b1;
      bus.term_valid = 1'b1;
      bus.term_data  = 16'h0180;
      tick();
      bus.term_data  = 16'h0340;
      n_vec++;
      if (bus.add_a !== 16'h0180) begin n_err++; $display("FAIL b2b_add_a: got %h want 0180", bus.add_a); end
      n_vec++;
      if (bus.add_b !== 16'h0340) begin n_err++; $display("FAIL b2b_add_b: got %h want 0340", bus.add_b); end
      n_vec++;
      if (bus.term_count !== 2'd1) begin n_err++; $display("FAIL b2b_count1: got %0d want 1", bus.term_count); end
      tick();
      bus.term_data  = 16'h8100;
      tick();
      bus.term_valid = 1'b0;
      n_vec++;
      if (bus.sum_valid !== 1'b1) begin n_err++; $display("FAIL b2b_sum_valid: got %b want 1", bus.sum_valid); end
      n_vec++;
      if (bus.term_ready !== 1'b0) begin n_err++; $display("FAIL b2b_term_ready_hold: got %b want 0", bus.term_ready); end
      n_vec++;
      if (bus.sum_data !== 16'h03C0) begin n_err++; $display("FAIL b2b_sum_data: got %h want 03c0", bus.sum_data); end
      n_vec++;
      if (bus.sum_ovf !== 1'b0) begin n_err++; $display("FAIL b2b_sum_ovf: got %b want 0", bus.sum_ovf); end
      n_vec++;
      if (bus.term_count !== 2'd3) begin n_err++; $display("FAIL b2b_count3: got %0d want 3", bus.term_count); end
      tick();
      n_vec++;
      if (bus.sum_valid !== 1'b0) begin n_err++; $display("FAIL b2b_one_cycle_valid: got %b want 0", bus.sum_valid); end
      n_vec++;
      if (bus.term_ready !== 1'b1) begin n_err++; $display("FAIL b2b_term_ready_back: got %b want 1", bus.term_ready); end
      n_vec++;
      if (bus.term_count !== 2'd0) begin n_err++; $display("FAIL b2b_count0: got %0d want 0", bus.term_count); end
   endtask

   task automatic test_neg_zero();
      bus.sum_ready  = 1'b1;
      bus.term_valid = 1'b1;
      bus.term_data  = 16'h0180;
      tick();
      bus.term_data  = 16'h8180;
      tick();
      n_vec++;
      if (bus.add_a !== 16'h0000) begin n_err++; $display("FAIL nz_acc_after_cancel: got %h want 0000", bus.add_a); end
      bus.term_data  = 16'h0000;
      tick();
      bus.term_valid = 1'b0;
      n_vec++;
      if (bus.sum_data !== 16'h0000) begin n_err++; $display("FAIL nz_sum_data: got %h want 0000", bus.sum_data); end
      n_vec++;
      if (bus.sum_ovf !== 1'b0) begin n_err++; $display("FAIL nz_sum_ovf: got %b want 0", bus.sum_ovf); end
      tick();
      // A lone negative-zero first term must also fold to zero.
      feed3(16'h8000, 16'h8000, 16'h8000);
      n_vec++;
      if (bus.sum_data !== 16'h0000) begin n_err++; $display("FAIL nz_all_negzero: got %h want 0000", bus.sum_data); end
      tick();
   endtask

   task automatic test_overflow();
      bus.sum_ready = 1'b1;
      feed3(16'h7F00, 16'h0200, 16'h0000);
      n_vec++;
      if (bus.sum_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", bus.sum_ovf); end
      n_vec++;
      if (bus.sum_data !== 16'h0100) begin n_err++; $display("FAIL ovf_wrapped_data: got %h want 0100", bus.sum_data); end
      tick();
      feed3(16'h0001, 16'h0001, 16'h0001);
      n_vec++;
      if (bus.sum_data !== 16'h0003) begin n_err++; $display("FAIL ovf_next_data: got %h want 0003", bus.sum_data); end
      n_vec++;
      if (bus.sum_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_next_clean: got %b want 0", bus.sum_ovf); end
      tick();
      // Negative operands overflowing in the negative direction.
      feed3(16'hC000, 16'hC000, 16'h8001);
      n_vec++;
      if (bus.sum_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_negative: got %b want 1", bus.sum_ovf); end
      n_vec++;
      if (bus.sum_data !== 16'h8001) begin n_err++; $display("FAIL ovf_negative_data: got %h want 8001", bus.sum_data); end
      tick();
   endtask

   task automatic test_backpressure();
      bus.sum_ready = 1'b0;
      feed3(16'h0010, 16'h0020, 16'h0030);
      bus.term_valid = 1'b1;
      bus.term_data  = 16'h0555;
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (bus.sum_data !== 16'h0060) begin n_err++; $display("FAIL bp_sum_stable[%0d]: got %h want 0060", i, bus.sum_data); end
         n_vec++;
         if (bus.term_ready !== 1'b0) begin n_err++; $display("FAIL bp_term_ready[%0d]: got %b want 0", i, bus.term_ready); end
         n_vec++;
         if (bus.sum_valid !== 1'b1) begin n_err++; $display("FAIL bp_sum_valid[%0d]: got %b want 1", i, bus.sum_valid); end
         tick();
      end
      bus.sum_ready = 1'b1;
      tick();
      n_vec++;
      if (bus.sum_valid !== 1'b0) begin n_err++; $display("FAIL bp_handshake: got %b want 0", bus.sum_valid); end
      n_vec++;
      if (bus.term_count !== 2'd0) begin n_err++; $display("FAIL bp_count_after_hs: got %0d want 0", bus.term_count); end
      tick();
      n_vec++;
      if (bus.term_count !== 2'd1) begin n_err++; $display("FAIL bp_pending_accepted: got %0d want 1", bus.term_count); end
      n_vec++;
      if (bus.add_a !== 16'h0555) begin n_err++; $display("FAIL bp_pending_first: got %h want 0555", bus.add_a); end
      bus.term_data  = 16'h0001;
      tick();
      bus.term_data  = 16'h8002;
      tick();
      bus.term_valid = 1'b0;
      n_vec++;
      if (bus.sum_data !== 16'h0554) begin n_err++; $display("FAIL bp_next_sum: got %h want 0554", bus.sum_data); end
      tick();
   endtask

   task automatic test_clear();
      bus.sum_ready  = 1'b1;
      bus.term_valid = 1'b1;
      bus.term_data  = 16'h7F00;
      tick();
      bus.term_data  = 16'h0200;
      clear          = 1'b1;
      tick();
      clear          = 1'b0;
      bus.term_valid = 1'b0;
      n_vec++;
      if (bus.term_count !== 2'd0) begin n_err++; $display("FAIL clr_count: got %0d want 0", bus.term_count); end
      n_vec++;
      if (bus.add_a !== 16'h0000) begin n_err++; $display("FAIL clr_acc: got %h want 0000", bus.add_a); end
      feed3(16'h0011, 16'h0022, 16'h0033);
      n_vec++;
      if (bus.sum_data !== 16'h0066) begin n_err++; $display("FAIL clr_clean_sum: got %h want 0066", bus.sum_data); end
      n_vec++;
      if (bus.sum_ovf !== 1'b0) begin n_err++; $display("FAIL clr_clean_ovf: got %b want 0", bus.sum_ovf); end
      tick();
      // clear while holding a sum discards it.
      bus.sum_ready = 1'b0;
      feed3(16'h0004, 16'h0004, 16'h0004);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      n_vec++;
      if (bus.sum_valid !== 1'b0) begin n_err++; $display("FAIL clr_hold_valid: got %b want 0", bus.sum_valid); end
      n_vec++;
      if (bus.sum_data !== 16'h0000) begin n_err++; $display("FAIL clr_hold_data: got %h want 0000", bus.sum_data); end
   endtask

   task automatic test_async_reset();
      bus.sum_ready = 1'b0;
      feed3(16'h0100, 16'h0200, 16'h0300);
      n_vec++;
      if (bus.sum_data !== 16'h0600) begin n_err++; $display("FAIL ar_pre_sum: got %h want 0600", bus.sum_data); end
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus.sum_valid !== 1'b0) begin n_err++; $display("FAIL ar_sum_valid: got %b want 0", bus.sum_valid); end
      n_vec++;
      if (bus.sum_data !== 16'h0000) begin n_err++; $display("FAIL ar_sum_data: got %h want 0000", bus.sum_data); end
      n_vec++;
      if (bus.term_count !== 2'd0) begin n_err++; $display("FAIL ar_term_count: got %0d want 0", bus.term_count); end
      bus.term_valid = 1'b1;
      bus.term_data  = 16'h7777;
      tick();
      n_vec++;
      if (bus.term_count !== 2'd0) begin n_err++; $display("FAIL ar_no_accept: got %0d want 0", bus.term_count); end
      bus.term_valid = 1'b0;
      rst_n          = 1'b1;
      bus.sum_ready  = 1'b1;
      tick();
      feed3(16'h0005, 16'h0006, 16'h8001);
      n_vec++;
      if (bus.sum_data !== 16'h000A) begin n_err++; $display("FAIL ar_after_sum: got %h want 000a", bus.sum_data); end
      n_vec++;
      if (bus.sum_valid !== 1'b1) begin n_err++; $display("FAIL ar_after_valid: got %b want 1", bus.sum_valid); end
      tick();
   endtask

   initial begin
      n_vec          = 0;
      n_err          = 0;
      rst_n          = 1'b0;
      clear          = 1'b0;
      bus.term_valid = 1'b0;
      bus.term_data  = 16'h0000;
      bus.sum_ready  = 1'b0;
      test_reset();
      test_back_to_back();
      test_neg_zero();
      test_overflow();
      test_backpressure();
      test_clear();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
